uart_transmitter: RTL and testbench

//  Serialises one DATA_WIDTH-bit word per request into a UART 8N1-style frame on tx.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_transmitter.sv | 135 +++++++++++++
 tb/tb_uart_transmitter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int STOP_TICKS_DEF = 16;

  // Counter width able to hold max(a, b) - 1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: one start bit, DATA_WIDTH data bits LSB first, stop bit held
// for STOP_TICKS oversample ticks. tx/tx_busy/tx_done are all registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_TICKS = STOP_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TW = cnt_width(OVERSAMPLE, STOP_TICKS);
  localparam int BW = cnt_width(DATA_WIDTH, 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  uart_state_t           state_r, state_s;
  logic [TW-1:0]         tick_cnt_r, tick_cnt_s;
  logic [BW-1:0]         bit_cnt_r, bit_cnt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  tx_r, tx_s;
  logic                  busy_r;
  logic                  done_r, done_s;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          shift_s    = data_in;
          tick_cnt_s = {TW{1'b0}};
          bit_cnt_s  = {BW{1'b0}};
          state_s    = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick && (tick_cnt_r == BIT_LAST)) begin
          tick_cnt_s = {TW{1'b0}};
          state_s    = DATA;
        end else if (tick) begin
          tick_cnt_s = tick_cnt_r + TW'(1);
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      DATA: begin
        if (tick && (tick_cnt_r == BIT_LAST)) begin
          tick_cnt_s = {TW{1'b0}};
          shift_s    = shift_r >> 1;
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = {BW{1'b0}};
            state_s   = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else if (tick) begin
          tick_cnt_s = tick_cnt_r + TW'(1);
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      STOP: begin
        // The done pulse is raised while still in STOP, so a request in that
        // cycle is ignored and the next one lands in IDLE.
        if (done_r) begin
          tick_cnt_s = {TW{1'b0}};
          state_s    = IDLE;
        end else if (tick && (tick_cnt_r == STOP_LAST)) begin
          done_s = 1'b1;
        end else if (tick) begin
          tick_cnt_s = tick_cnt_r + TW'(1);
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        tick_cnt_s = {TW{1'b0}};
        bit_cnt_s  = {BW{1'b0}};
      end
    endcase
  end

  // Line level for the current state; registered below, so tx trails state by one clk.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_r[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= {TW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-level line model plus a mid-bit decoder.
module tb_uart_transmitter;

  localparam int DW = 8;
  localparam int OS = 16;
  localparam int ST = 16;
  localparam int FRAME_TICKS = (1 + DW) * OS + ST;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          tick;
  logic          tx_start;
  logic [DW-1:0] data_in;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int total;
  int bad;

  // Model state: one frame occupies FRAME_TICKS ticks after the accept cycle.
  bit            m_busy;
  bit            m_exp_done;
  int            m_ticks;
  int            m_pend_k;
  int            acc_ticks;
  int            last_len;
  int            frames;
  int            done_seen;
  logic [DW-1:0] m_word;
  logic          samples [1:FRAME_TICKS];
  logic [DW-1:0] rx_q [$];

  bit tick_on;
  int tick_period;
  int tick_cnt;

  always #5 clk = ~clk;

  uart_transmitter #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS),
    .STOP_TICKS(ST)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .tick    (tick),
    .tx_start(tx_start),
    .data_in (data_in),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // Expected line level while tick k (1-based, after accept) is being counted.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    int idx;
    idx = (k - 1) / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    return 1'b1;
  endfunction

  task automatic tick_gen();
    forever begin
      @(posedge clk);
      #1;
      tick = tick_on && (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1) % tick_period;
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] w;
    logic          e;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        total += 3;
        if (tx !== 1'b1)      begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
        m_busy = 1'b0; m_exp_done = 1'b0; m_pend_k = 0; m_ticks = 0;
      end else begin
        total++;
        if (tx_done !== m_exp_done) begin
          bad++; $display("FAIL done_timing: got %b want %b at %0t", tx_done, m_exp_done, $time);
        end
        if (tx_done === 1'b1) begin done_seen++; last_len = acc_ticks; end
        total++;
        if (tx_busy !== m_busy) begin
          bad++; $display("FAIL busy: got %b want %b at %0t", tx_busy, m_busy, $time);
        end
        if (m_pend_k != 0) begin
          e = exp_bit(m_word, m_pend_k);
          samples[m_pend_k] = tx;
          total++;
          if (tx !== e) begin
            bad++; $display("FAIL tx_bit: tick %0d got %b want %b word %h", m_pend_k, tx, e, m_word);
          end
        end else if (!m_busy) begin
          total++;
          if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx: got %b want 1 at %0t", tx, $time); end
        end
        m_pend_k = 0;
        if (tick) acc_ticks++;
        if (m_exp_done) begin
          m_exp_done = 1'b0;
          m_busy = 1'b0;
          frames++;
          for (int i = 0; i < DW; i++) w[i] = samples[OS*(i+1) + OS/2];
          rx_q.push_back(w);
        end else if (!m_busy) begin
          if (tx_start) begin m_busy = 1'b1; m_word = data_in; m_ticks = 0; acc_ticks = 0; end
        end else if (tick) begin
          m_ticks++;
          m_pend_k = m_ticks;
          if (m_ticks == FRAME_TICKS) m_exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    @(posedge clk); #1;
    data_in = w; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (frames < target) begin bad++; $display("FAIL frame_timeout: frames %0d want %0d", frames, target); end
  endtask

  task automatic wait_ticks(input int t);
    int n = 0;
    while (m_ticks < t && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (m_ticks < t) begin bad++; $display("FAIL tick_timeout: ticks %0d want %0d", m_ticks, t); end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #20;
    total += 3;
    if (tx !== 1'b1)      begin bad++; $display("FAIL rst_during_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_during_busy: got %b want 0", tx_busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_during_done: got %b want 0", tx_done); end
    #30;
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    total += 3;
    if (tx !== 1'b1)      begin bad++; $display("FAIL rst_after_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy: got %b want 0", tx_busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_after_done: got %b want 0", tx_done); end
  endtask

  task automatic test_single();
    int f0 = frames;
    int d0 = done_seen;
    logic [DW-1:0] got;
    rx_q.delete();
    send(8'hA5);
    wait_frames(f0 + 1);
    @(negedge clk);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
    total += 3;
    if (got !== 8'hA5) begin bad++; $display("FAIL single_rx: got %h want a5", got); end
    if (done_seen - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_seen - d0); end
    if (last_len != 160) begin bad++; $display("FAIL frame_length: got %0d want 160", last_len); end
  endtask

  task automatic test_back_to_back();
    int f0 = frames;
    int n = 0;
    logic [DW-1:0] got;
    rx_q.delete();
    send(8'h00);
    while (tx_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    data_in = 8'hFF; tx_start = 1'b1;
    @(negedge clk);
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_gap: busy got %b want 0", tx_busy); end
    @(negedge clk);
    total++;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", tx_busy); end
    tx_start = 1'b0;
    wait_frames(f0 + 2);
    total += 2;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
    if (got !== 8'h00) begin bad++; $display("FAIL b2b_rx0: got %h want 00", got); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
    if (got !== 8'hFF) begin bad++; $display("FAIL b2b_rx1: got %h want ff", got); end
  endtask

  task automatic test_held_start();
    int f0 = frames;
    logic [DW-1:0] w = DW'($urandom);
    logic [DW-1:0] got;
    rx_q.delete();
    @(posedge clk); #1;
    data_in = w; tx_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      @(negedge clk);
      while (tx_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    end
    tx_start = 1'b0;
    repeat (50) @(negedge clk);
    total += 2;
    if (frames - f0 != 3) begin bad++; $display("FAIL held_frames: got %0d want 3", frames - f0); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL held_idle: busy got %b want 0", tx_busy); end
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : ~w;
      total++;
      if (got !== w) begin bad++; $display("FAIL held_rx%0d: got %h want %h", i, got, w); end
    end
  endtask

  task automatic test_busy_ignore();
    int f0 = frames;
    int d0 = done_seen;
    logic [DW-1:0] got;
    rx_q.delete();
    send(8'h55);
    wait_ticks(60);
    @(posedge clk); #1;
    data_in = 8'h3C; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_frames(f0 + 1);
    repeat (OS * tick_period * 12) @(negedge clk);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h3C;
    total += 4;
    if (got !== 8'h55) begin bad++; $display("FAIL ignore_rx: got %h want 55", got); end
    if (frames - f0 != 1) begin bad++; $display("FAIL ignore_frames: got %0d want 1", frames - f0); end
    if (done_seen - d0 != 1) begin bad++; $display("FAIL ignore_done: got %0d want 1", done_seen - d0); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL ignore_idle: busy got %b want 0", tx_busy); end
  endtask

  task automatic test_no_tick();
    int f0 = frames;
    int d0 = done_seen;
    logic [DW-1:0] w = DW'($urandom);
    logic [DW-1:0] got;
    rx_q.delete();
    send(w);
    wait_ticks(100);
    tick_on = 1'b0;
    repeat (300) @(negedge clk);
    total += 2;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", tx_busy); end
    if (done_seen != d0) begin bad++; $display("FAIL hold_done: got %0d want %0d", done_seen, d0); end
    tick_on = 1'b1;
    wait_frames(f0 + 1);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : ~w;
    total++;
    if (got !== w) begin bad++; $display("FAIL hold_rx: got %h want %h", got, w); end
  endtask

  task automatic test_mid_reset();
    int f0 = frames;
    int d0;
    logic [DW-1:0] got;
    rx_q.delete();
    send(8'hF0);
    wait_ticks(70);
    @(negedge clk); #2;
    d0 = done_seen;
    arst_n = 1'b0;
    #1;
    total += 3;
    if (tx !== 1'b1)      begin bad++; $display("FAIL midrst_tx: got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", tx_done); end
    #30;
    @(negedge clk); #2;
    arst_n = 1'b1;
    repeat (OS * tick_period * 2) @(negedge clk);
    total += 2;
    if (done_seen != d0) begin bad++; $display("FAIL midrst_nodone: got %0d want %0d", done_seen, d0); end
    if (frames != f0) begin bad++; $display("FAIL midrst_frames: got %0d want %0d", frames, f0); end
    send(8'h81);
    wait_frames(f0 + 1);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h7E;
    total++;
    if (got !== 8'h81) begin bad++; $display("FAIL midrst_rx: got %h want 81", got); end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    logic [DW-1:0] got;
    for (int i = 0; i < 4; i++) begin
      int f0 = frames;
      rx_q.delete();
      tick_period = $urandom_range(3, 6);
      w = DW'($urandom);
      repeat ($urandom_range(1, 9)) @(posedge clk);
      send(w);
      wait_frames(f0 + 1);
      got = (rx_q.size() > 0) ? rx_q.pop_front() : ~w;
      total += 2;
      if (got !== w) begin bad++; $display("FAIL rand_rx%0d: got %h want %h", i, got, w); end
      if (last_len != FRAME_TICKS) begin bad++; $display("FAIL rand_len%0d: got %0d want %0d", i, last_len, FRAME_TICKS); end
    end
  endtask

  initial begin
    arst_n = 1'b1; tx_start = 1'b0; data_in = '0; tick = 1'b0;
    tick_on = 1'b1; tick_period = 4; tick_cnt = 0;
    total = 0; bad = 0;
    m_busy = 1'b0; m_exp_done = 1'b0; m_ticks = 0; m_pend_k = 0;
    acc_ticks = 0; last_len = 0; frames = 0; done_seen = 0; m_word = '0;
    #1;
    fork
      tick_gen();
      monitor();
    join_none
    test_reset();
    tick_period = $urandom_range(3, 6);
    test_single();
    test_back_to_back();
    test_held_start();
    test_busy_ignore();
    test_no_tick();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
